// File: rtl/armleo_operand_fetch.sv
// Operand fetch between decoder and 2R/1W regfile; writeback forwarding when ARMLEO_OPFETCH_BYPASS_EN, else stale/re-read.
// Latency: accept to out_valid is 1 cycle (plus 1 re-issue cycle per colliding write without bypass).
// Backpressure: one held entry; in_ready only when empty or draining this cycle; flush discards the entry.
module armleo_operand_fetch #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEPTH_LOG2-1:0] in_rs1_addr,
    input  logic [DEPTH_LOG2-1:0] in_rs2_addr,
    output logic                  rs1_read,
    output logic                  rs2_read,
    output logic [DEPTH_LOG2-1:0] rs1_addr,
    output logic [DEPTH_LOG2-1:0] rs2_addr,
    input  logic [WIDTH-1:0]      rs1_rdata,
    input  logic [WIDTH-1:0]      rs2_rdata,
    input  logic                  rd_write,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic [WIDTH-1:0]      rd_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_rs1_data,
    output logic [WIDTH-1:0]      out_rs2_data
);

    logic                  b_valid;
    logic                  b_fresh;
    logic                  b_stale;
    logic [DEPTH_LOG2-1:0] b_rs1_addr;
    logic [DEPTH_LOG2-1:0] b_rs2_addr;
    logic [WIDTH-1:0]      b_rs1_data;
    logic [WIDTH-1:0]      b_rs2_data;
    logic [WIDTH-1:0]      fresh1;
    logic [WIDTH-1:0]      fresh2;

    logic accept;
    logic handshake;
    logic reissue;
    logic stale_set;
    logic wr_nz;
    logic hit_in1, hit_in2, hit_b1, hit_b2;

    assign wr_nz   = rd_write && (rd_addr != '0);
    assign hit_in1 = wr_nz && (rd_addr == in_rs1_addr);
    assign hit_in2 = wr_nz && (rd_addr == in_rs2_addr);
    assign hit_b1  = wr_nz && (rd_addr == b_rs1_addr);
    assign hit_b2  = wr_nz && (rd_addr == b_rs2_addr);

    assign out_valid = b_valid && !b_stale && !flush;
    assign handshake = out_valid && out_ready;
    assign in_ready  = !rst && !flush && (!b_valid || handshake);
    assign accept    = in_valid && in_ready;
    assign reissue   = b_valid && b_stale && !flush;

    // Read ports show the new request on accept, otherwise the last issued addresses.
    assign rs1_read = accept || reissue;
    assign rs2_read = accept || reissue;
    assign rs1_addr = accept ? in_rs1_addr : b_rs1_addr;
    assign rs2_addr = accept ? in_rs2_addr : b_rs2_addr;

    assign out_rs1_data = (b_rs1_addr == '0) ? '0 : (b_fresh ? fresh1 : b_rs1_data);
    assign out_rs2_data = (b_rs2_addr == '0) ? '0 : (b_fresh ? fresh2 : b_rs2_data);

`ifdef ARMLEO_OPFETCH_BYPASS_EN
    logic             fwd1, fwd2;
    logic [WIDTH-1:0] fwd1_data, fwd2_data;

    assign b_stale   = 1'b0;
    assign stale_set = 1'b0;
    assign fresh1    = fwd1 ? fwd1_data : rs1_rdata;
    assign fresh2    = fwd2 ? fwd2_data : rs2_rdata;

    // Regfile read-during-write data is undefined, so the issue-cycle write is captured here instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd1      <= 1'b0;
            fwd2      <= 1'b0;
            fwd1_data <= '0;
            fwd2_data <= '0;
        end else begin
            fwd1 <= accept && hit_in1;
            fwd2 <= accept && hit_in2;
            if (accept && hit_in1) fwd1_data <= rd_wdata;
            if (accept && hit_in2) fwd2_data <= rd_wdata;
        end
    end
`else
    assign fresh1    = rs1_rdata;
    assign fresh2    = rs2_rdata;
    assign stale_set = !flush && ((accept && (hit_in1 || hit_in2)) ||
                                  (b_valid && !handshake && (hit_b1 || hit_b2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) b_stale <= 1'b0;
        else     b_stale <= stale_set;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid    <= 1'b0;
            b_fresh    <= 1'b0;
            b_rs1_addr <= '0;
            b_rs2_addr <= '0;
            b_rs1_data <= '0;
            b_rs2_data <= '0;
        end else begin
            if (flush)          b_valid <= 1'b0;
            else if (accept)    b_valid <= 1'b1;
            else if (handshake) b_valid <= 1'b0;

            b_fresh <= !flush && (accept || reissue) && !stale_set;

            if (accept) begin
                b_rs1_addr <= in_rs1_addr;
                b_rs2_addr <= in_rs2_addr;
            end

            if (b_valid && b_fresh) begin
                b_rs1_data <= fresh1;
                b_rs2_data <= fresh2;
            end
`ifdef ARMLEO_OPFETCH_BYPASS_EN
            // Held-operand update wins over the fresh-cycle load so the write is not lost.
            if (b_valid && hit_b1) b_rs1_data <= rd_wdata;
            if (b_valid && hit_b2) b_rs2_data <= rd_wdata;
`endif
        end
    end

endmodule
